// File: rtl/tlp_rx_tap.sv
// Passive tap on the 64-bit AXI-Stream PCIe RX TLP interface. Each captured TLP is
// written into the RX snoop FIFO one word per beat, delayed by one beat so that the
// total byte length and tag, decoded from the first two beats, travel on every word.
// FIFO word layout, MSB first:
//   din[98:83] tlp_len, din[82:75] tlp_tag, din[74] tvalid, din[73] tlast,
//   din[72:65] tkeep, din[64:1] tdata, din[0] tuser
module tlp_rx_tap #(
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 pcie_clk,
  input  logic                 pcie_rst_n,
  input  logic                 rx_tvalid,
  input  logic                 rx_tready,
  input  logic [63:0]          rx_tdata,
  input  logic [7:0]           rx_tkeep,
  input  logic                 rx_tlast,
  input  logic                 snoop_en,
  input  logic                 fifo_prog_full,
  output logic                 wr_en,
  output logic [98:0]          din,
  output logic [CNT_WIDTH-1:0] pkt_cnt,
  output logic [CNT_WIDTH-1:0] drop_cnt,
  output logic [CNT_WIDTH-1:0] err_cnt
);

  typedef enum logic [1:0] {StIdle, StHdr2, StPass, StDrop} state_e;

  state_e               state_q, state_d;
  logic                 dly_vld_q, dly_vld_d;
  logic                 dly_last_q, dly_last_d;
  logic [7:0]           dly_keep_q, dly_keep_d;
  logic [63:0]          dly_data_q, dly_data_d;
  logic [15:0]          len_q, len_d;
  logic [7:0]           tag_q, tag_d;
  logic [CNT_WIDTH-1:0] pkt_q, pkt_d;
  logic [CNT_WIDTH-1:0] drop_q, drop_d;
  logic [CNT_WIDTH-1:0] err_q, err_d;

  logic        acc;
  logic [10:0] dw_cnt;
  logic [15:0] calc_len;
  logic [7:0]  calc_tag;

  assign acc = rx_tvalid & rx_tready;

  // Header decode works on the buffered header beat (DW0 in the low half).
  // A zero length field encodes 1024 DWs.
  assign dw_cnt   = (dly_data_q[9:0] == 10'd0) ? 11'd1024 : {1'b0, dly_data_q[9:0]};
  assign calc_len = (dly_data_q[29] ? 16'd16 : 16'd12)
                  + (dly_data_q[30] ? {3'b000, dw_cnt, 2'b00} : 16'd0);
  // Completions carry their tag in DW2 (second beat); requests in DW1.
  assign calc_tag = (dly_data_q[28:24] == 5'b01010) ? rx_tdata[15:8] : dly_data_q[47:40];

  // Next-state, FIFO write and counter logic; outputs zero whenever nothing is written.
  always_comb begin
    state_d    = state_q;
    dly_vld_d  = dly_vld_q;
    dly_last_d = dly_last_q;
    dly_keep_d = dly_keep_q;
    dly_data_d = dly_data_q;
    len_d      = len_q;
    tag_d      = tag_q;
    pkt_d      = pkt_q;
    drop_d     = drop_q;
    err_d      = err_q;
    wr_en      = 1'b0;
    din        = '0;

    unique case (state_q)
      StIdle: begin
        // Flush the buffered last beat of the previous TLP.
        if (dly_vld_q) begin
          wr_en     = 1'b1;
          din       = {len_q, tag_q, 1'b1, dly_last_q, dly_keep_q, dly_data_q, 1'b0};
          dly_vld_d = 1'b0;
          pkt_d     = pkt_q + CNT_WIDTH'(1);
        end
        if (acc) begin
          if (rx_tlast) begin
            err_d = err_q + CNT_WIDTH'(1);
          end else if (!snoop_en || fifo_prog_full) begin
            state_d = StDrop;
          end else begin
            dly_vld_d  = 1'b1;
            dly_last_d = rx_tlast;
            dly_keep_d = rx_tkeep;
            dly_data_d = rx_tdata;
            state_d    = StHdr2;
          end
        end
      end
      StHdr2: begin
        if (acc) begin
          wr_en      = 1'b1;
          din        = {calc_len, calc_tag, 1'b1, dly_last_q, dly_keep_q, dly_data_q, 1'b0};
          len_d      = calc_len;
          tag_d      = calc_tag;
          dly_vld_d  = 1'b1;
          dly_last_d = rx_tlast;
          dly_keep_d = rx_tkeep;
          dly_data_d = rx_tdata;
          state_d    = rx_tlast ? StIdle : StPass;
        end
      end
      StPass: begin
        if (acc) begin
          wr_en      = 1'b1;
          din        = {len_q, tag_q, 1'b1, dly_last_q, dly_keep_q, dly_data_q, 1'b0};
          dly_vld_d  = 1'b1;
          dly_last_d = rx_tlast;
          dly_keep_d = rx_tkeep;
          dly_data_d = rx_tdata;
          if (rx_tlast) state_d = StIdle;
        end
      end
      StDrop: begin
        if (acc && rx_tlast) begin
          drop_d  = drop_q + CNT_WIDTH'(1);
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, delay register, metadata and counter registers.
  always_ff @(posedge pcie_clk or negedge pcie_rst_n) begin
    if (!pcie_rst_n) begin
      state_q    <= StIdle;
      dly_vld_q  <= 1'b0;
      dly_last_q <= 1'b0;
      dly_keep_q <= '0;
      dly_data_q <= '0;
      len_q      <= '0;
      tag_q      <= '0;
      pkt_q      <= '0;
      drop_q     <= '0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      dly_vld_q  <= dly_vld_d;
      dly_last_q <= dly_last_d;
      dly_keep_q <= dly_keep_d;
      dly_data_q <= dly_data_d;
      len_q      <= len_d;
      tag_q      <= tag_d;
      pkt_q      <= pkt_d;
      drop_q     <= drop_d;
      err_q      <= err_d;
    end
  end

  assign pkt_cnt  = pkt_q;
  assign drop_cnt = drop_q;
  assign err_cnt  = err_q;

endmodule

// File: tb/tb_tlp_rx_tap.sv
// Directed bench for tlp_rx_tap: stimulus pushes expected FIFO words into a queue, a
// monitor pops and compares on every FIFO write.
module tb_tlp_rx_tap;

  logic        pcie_clk;
  logic        pcie_rst_n;
  logic        rx_tvalid;
  logic        rx_tready;
  logic [63:0] rx_tdata;
  logic [7:0]  rx_tkeep;
  logic        rx_tlast;
  logic        snoop_en;
  logic        fifo_prog_full;
  logic        wr_en;
  logic [98:0] din;
  logic [31:0] pkt_cnt;
  logic [31:0] drop_cnt;
  logic [31:0] err_cnt;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          last_acc_cyc = -1;
  logic [98:0] exp_q[$];
  logic [98:0] exp_w;

  tlp_rx_tap #(.CNT_WIDTH(32)) dut (
    .pcie_clk       (pcie_clk),
    .pcie_rst_n     (pcie_rst_n),
    .rx_tvalid      (rx_tvalid),
    .rx_tready      (rx_tready),
    .rx_tdata       (rx_tdata),
    .rx_tkeep       (rx_tkeep),
    .rx_tlast       (rx_tlast),
    .snoop_en       (snoop_en),
    .fifo_prog_full (fifo_prog_full),
    .wr_en          (wr_en),
    .din            (din),
    .pkt_cnt        (pkt_cnt),
    .drop_cnt       (drop_cnt),
    .err_cnt        (err_cnt)
  );

  initial pcie_clk = 1'b0;
  always #5 pcie_clk = ~pcie_clk;

  always @(posedge pcie_clk) cyc <= cyc + 1;

  function automatic logic [98:0] mk_word(input logic [15:0] len, input logic [7:0] tag,
                                          input logic last, input logic [7:0] keep,
                                          input logic [63:0] data);
    return {len, tag, 1'b1, last, keep, data, 1'b0};
  endfunction

  function automatic logic [63:0] beat_data(input logic [63:0] hdr, input logic [63:0] b1,
                                            input int i);
    if (i == 0) return hdr;
    if (i == 1) return b1;
    return {32'hA500_0000 | 32'(i), 32'h5A00_0000 | 32'(i)};
  endfunction

  // Monitor: every FIFO write must match the head of the expected queue; the last
  // word of a TLP must appear in the cycle right after its beat was accepted.
  always @(negedge pcie_clk) begin
    if (pcie_rst_n && wr_en) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_write: got din=%h, required no write", din);
      end else begin
        exp_w = exp_q.pop_front();
        if (din !== exp_w) begin
          n_bad++;
          $display("FAIL fifo_word: got din=%h required %h", din, exp_w);
        end
        if (exp_w[73]) begin
          n_cmp++;
          if (cyc != last_acc_cyc) begin
            n_bad++;
            $display("FAIL tlast_latency: got write at cycle %0d required cycle %0d",
                     cyc, last_acc_cyc);
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [98:0] act, input logic [98:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge pcie_clk);
      #1;
    end
  endtask

  // Present one beat, optionally holding it with rx_tready low for some cycles.
  task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l,
                           input int stall);
    rx_tdata  = d;
    rx_tkeep  = k;
    rx_tlast  = l;
    rx_tvalid = 1'b1;
    rx_tready = 1'b0;
    repeat (stall) begin
      @(posedge pcie_clk);
      #1;
    end
    rx_tready = 1'b1;
    @(posedge pcie_clk);
    #1;
    if (l) last_acc_cyc = cyc;
    rx_tvalid = 1'b0;
    rx_tlast  = 1'b0;
  endtask

  // Send a whole TLP back to back; fifo_prog_full is released after the header beat.
  task automatic send_tlp(input logic [63:0] hdr, input logic [63:0] b1, input int n,
                          input logic [7:0] last_keep, input logic [15:0] len,
                          input logic [7:0] tag, input bit cap, input int stall_at);
    if (cap) begin
      for (int i = 0; i < n; i++) begin
        exp_q.push_back(mk_word(len, tag, i == n - 1, (i == n - 1) ? last_keep : 8'hFF,
                                beat_data(hdr, b1, i)));
      end
    end
    for (int i = 0; i < n; i++) begin
      send_beat(beat_data(hdr, b1, i), (i == n - 1) ? last_keep : 8'hFF, i == n - 1,
                (i == stall_at) ? 2 : 0);
      if (i == 0) fifo_prog_full = 1'b0;
    end
  endtask

  initial begin
    pcie_rst_n     = 1'b1;
    rx_tvalid      = 1'b0;
    rx_tready      = 1'b1;
    rx_tdata       = '0;
    rx_tkeep       = '0;
    rx_tlast       = 1'b0;
    snoop_en       = 1'b1;
    fifo_prog_full = 1'b0;
    #1 pcie_rst_n = 1'b0;
    #2;
    chk("rst_wr_en", 99'(wr_en), 99'd0);
    chk("rst_din", din, 99'd0);
    chk("rst_pkt_cnt", 99'(pkt_cnt), 99'd0);
    chk("rst_drop_cnt", 99'(drop_cnt), 99'd0);
    chk("rst_err_cnt", 99'(err_cnt), 99'd0);
    idle(3);
    pcie_rst_n = 1'b1;
    idle(2);

    // MRd 3DW: len 12, tag from DW1[15:8]
    send_tlp(64'h0100_050F_0000_0001, 64'h0000_0000_1234_5678, 2, 8'h0F, 16'd12, 8'h05,
             1'b1, -1);
    idle(3);
    chk("mrd_pkt_cnt", 99'(pkt_cnt), 99'd1);

    // MWr 4DW, 2 DW payload: len 24
    send_tlp(64'h0000_1200_6000_0002, 64'h0000_0000_8000_0000, 3, 8'hFF, 16'd24, 8'h12,
             1'b1, -1);
    idle(3);
    chk("mwr_pkt_cnt", 99'(pkt_cnt), 99'd2);

    // CplD: tag comes from second beat (0x07), not header DW1 (0x99)
    send_tlp(64'h0000_9900_4A00_0001, 64'hDEAD_BEEF_0000_0700, 2, 8'hFF, 16'd16, 8'h07,
             1'b1, -1);
    idle(3);
    chk("cpld_pkt_cnt", 99'(pkt_cnt), 99'd3);

    // Two MRds with zero gap and tready stalls mid-TLP
    send_tlp(64'h0100_2A0F_0000_0001, 64'h0000_0000_AAAA_0001, 2, 8'h0F, 16'd12, 8'h2A,
             1'b1, 1);
    send_tlp(64'h0100_2B0F_0000_0001, 64'h0000_0000_BBBB_0002, 2, 8'h0F, 16'd12, 8'h2B,
             1'b1, 1);
    idle(3);
    chk("b2b_pkt_cnt", 99'(pkt_cnt), 99'd5);

    // prog_full at header, released mid-TLP: whole TLP dropped, next one captured
    fifo_prog_full = 1'b1;
    send_tlp(64'h0000_4400_6000_0002, 64'h0000_0000_9000_0000, 3, 8'hFF, 16'd24, 8'h44,
             1'b0, -1);
    send_tlp(64'h0100_3C0F_0000_0001, 64'h0000_0000_CCCC_0003, 2, 8'h0F, 16'd12, 8'h3C,
             1'b1, -1);
    idle(3);
    chk("pf_drop_cnt", 99'(drop_cnt), 99'd1);
    chk("pf_pkt_cnt", 99'(pkt_cnt), 99'd6);

    // snoop disabled: dropped
    snoop_en = 1'b0;
    send_tlp(64'h0100_4D0F_0000_0001, 64'h0000_0000_DDDD_0004, 2, 8'h0F, 16'd12, 8'h4D,
             1'b0, -1);
    snoop_en = 1'b1;
    idle(3);
    chk("snoop_drop_cnt", 99'(drop_cnt), 99'd2);

    // Single-beat malformed TLP
    send_tlp(64'h0100_5E0F_0000_0001, 64'h0, 1, 8'hFF, 16'd12, 8'h5E, 1'b0, -1);
    idle(3);
    chk("err_cnt", 99'(err_cnt), 99'd1);
    chk("err_pkt_cnt", 99'(pkt_cnt), 99'd6);

    // MWr 3DW with length field 0 (1024 DW): 514 beats, len 4108
    send_tlp(64'h0000_3300_4000_0000, 64'h0000_0000_0000_1000, 514, 8'h0F, 16'd4108,
             8'h33, 1'b1, 7);
    idle(3);
    chk("max_pkt_cnt", 99'(pkt_cnt), 99'd7);

    // Reset in the middle of a TLP while a header write is being presented
    send_beat(64'h0000_5500_6000_0002, 8'hFF, 1'b0, 0);
    rx_tdata  = 64'h1111_2222_3333_4444;
    rx_tkeep  = 8'hFF;
    rx_tlast  = 1'b0;
    rx_tvalid = 1'b1;
    rx_tready = 1'b1;
    #2 pcie_rst_n = 1'b0;
    #1;
    chk("midrst_wr_en", 99'(wr_en), 99'd0);
    chk("midrst_din", din, 99'd0);
    chk("midrst_pkt_cnt", 99'(pkt_cnt), 99'd0);
    chk("midrst_drop_cnt", 99'(drop_cnt), 99'd0);
    chk("midrst_err_cnt", 99'(err_cnt), 99'd0);
    rx_tvalid = 1'b0;
    idle(2);
    pcie_rst_n = 1'b1;
    idle(1);

    // Fresh TLP after reset is captured as from power-up
    send_tlp(64'h0100_610F_0000_0001, 64'h0000_0000_EEEE_0005, 2, 8'h0F, 16'd12, 8'h61,
             1'b1, -1);
    idle(3);
    chk("post_rst_pkt_cnt", 99'(pkt_cnt), 99'd1);
    chk("queue_drained", 99'(exp_q.size()), 99'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tlp_rx_tap.md
Name: tlp_rx_tap

Overview:
- Passive tap on the PCIe core's 64-bit AXI-Stream RX TLP interface, in the PCIe clock domain.
- Decodes each TLP header to derive total TLP byte length and tag, then writes the TLP beat by beat into the RX snoop FIFO, metadata attached to every word.
- The FIFO's read side feeds the Ethernet encapsulator, which needs tlp_len and tlp_tag valid on the first word it reads.
- Never backpressures the PCIe core. TLPs that cannot be fully buffered are dropped whole and counted.

Parameters:
- CNT_WIDTH, 32, width of statistics counters.

Ports:
- pcie_clk  in  1  PCIe user clock; all logic on rising edge.
- pcie_rst_n  in  1  asynchronous active-low reset.
- rx_tvalid  in  1  PCIe RX beat valid.
- rx_tready  in  1  PCIe RX ready, as driven by the real consumer; observed only.
- rx_tdata  in  64  beat data; DW0 in [31:0], DW1 in [63:32].
- rx_tkeep  in  8  byte enables.
- rx_tlast  in  1  end of TLP.
- snoop_en  in  1  capture enable, sampled at TLP start.
- fifo_prog_full  in  1  FIFO has fewer than 514 free words.
- wr_en  out  1  FIFO write strobe.
- din  out  PCIE_FIFO64_RX  FIFO word; fields tlp_len, tlp_tag, tvalid, tlast, tkeep, tdata, tuser.
- pkt_cnt  out  CNT_WIDTH  TLPs written.
- drop_cnt  out  CNT_WIDTH  TLPs dropped.
- err_cnt  out  CNT_WIDTH  malformed TLPs (tlast on first beat).

Behaviour:
- Reset (async assert, sync release):
  - wr_en=0, din all zero.
  - All counters 0.
  - State IDLE; delay register invalid.
- Beat accepted only when rx_tvalid & rx_tready.
- States:
  - IDLE: first accepted beat is the header beat.
    - rx_tlast=1 → err_cnt++, stay IDLE.
    - else snoop_en=0 or fifo_prog_full=1 → DROP.
    - else capture beat into delay register → HDR2.
  - HDR2: next accepted beat.
    - Compute tag: completion (DW0[28:24]==5'b01010) → beat2 tdata[15:8]; otherwise → header beat tdata[47:40].
    - Latch tlp_len/tag into meta regs.
    - Write header beat.
    - Capture beat2 into delay register.
    - → IDLE if rx_tlast, else PASS.
  - PASS: each accepted beat writes the delayed beat and captures the new one; rx_tlast → IDLE.
  - DROP: discard beats; on rx_tlast → IDLE, drop_cnt++.
- tlp_len arithmetic, 16 bits:
  - hdr = DW0[29] ? 16 : 12.
  - data present when DW0[30]=1; dw = DW0[9:0], with 0 meaning 1024.
  - tlp_len = hdr + (DW0[30] ? dw*4 : 0); maximum 4112.
- Delay register holding a tlast beat is written the next cycle unconditionally, including in IDLE. pkt_cnt++ on that write.
- A simultaneously accepted new header beat in that cycle is captured normally (back-to-back TLPs, zero gap).
- din fields:
  - tvalid=1; tlast/tkeep/tdata copied from the beat.
  - tuser=0.
  - tlp_len/tlp_tag identical on every word of a TLP.
- Latency: header beat written 1 accepted beat later. Last beat written exactly 1 cycle after acceptance.
- fifo_prog_full is not re-checked mid-TLP: the 514-word threshold guarantees space for a maximum-size TLP.
- Counters wrap modulo 2^CNT_WIDTH.
- Reset mid-TLP:
  - Pending data discarded, no partial write completes.
  - The next TLP is handled as if from power-up.
  - Beats arriving after reset release, until the next tlast, are treated as a header beat plus body. This is accepted behaviour.

Test Plan:
- MRd 3DW, beat0 tdata=0x0100050F_00000001, beat1 tkeep=0x0F tlast:
  - 2 FIFO writes, tlp_len=12, tlp_tag=0x05.
  - Second write has tlast=1, tkeep=0x0F; pkt_cnt=1.
- MWr 4DW len=2 (DW0=0x60000002), 3 beats:
  - tlp_len=24, tag=DW1[15:8].
  - 3 writes; last write 1 cycle after the last input beat.
- CplD (DW0=0x4A000001), beat1 tdata[15:8]=0x07:
  - tlp_len=16, tlp_tag=0x07 on both words.
  - Tag taken from beat1, not from beat0.
- Back-to-back MRd TLPs with zero gap and rx_tready stalls inserted mid-TLP:
  - 4 writes in order, no beat lost or duplicated; pkt_cnt=2.
- fifo_prog_full=1 at a MWr header, then deasserted mid-TLP:
  - No writes for that TLP; drop_cnt=1.
  - Following TLP captured normally.
- Single-beat tlast TLP → err_cnt=1, no write. Then a length-0 MWr 3DW (DW0=0x40000000) → tlp_len=4108. Finally, assert reset mid-TLP → all outputs zero immediately.
